// File: rtl/led_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_scan_pkg
//  Description : Shared encodings for the LED scan controller: display modes,
//                FSM state codes, the default step-divider width and a helper
//                that maps a mode to the FSM state it starts in.
//  Ports       : (package, no ports)
//  Revision    : 1.0 - initial release
// ============================================================================
package led_scan_pkg;

    typedef logic [1:0] mode_t;
    typedef logic [2:0] state_t;

    localparam int c_DIV_W_DEFAULT = 24;

    // Display modes as written through the configuration port
    localparam mode_t c_MODE_OFF    = 2'd0;
    localparam mode_t c_MODE_SWEEP  = 2'd1;
    localparam mode_t c_MODE_BOUNCE = 2'd2;
    localparam mode_t c_MODE_BLINK  = 2'd3;

    // Scan FSM states
    localparam state_t c_ST_IDLE    = 3'd0;
    localparam state_t c_ST_FWD     = 3'd1;
    localparam state_t c_ST_REV     = 3'd2;
    localparam state_t c_ST_BLANK   = 3'd3;
    localparam state_t c_ST_BLK_ON  = 3'd4;
    localparam state_t c_ST_BLK_OFF = 3'd5;

    // State a mode begins in, whether entered from reset or from a config apply
    function automatic state_t first_state(input mode_t mode);
        case (mode)
            c_MODE_OFF:   return c_ST_IDLE;
            c_MODE_BLINK: return c_ST_BLK_ON;
            default:      return c_ST_FWD;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_step_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : led_step_prescaler
//  Description : Step-rate prescaler. Counts 0..div-1 while enabled and pulses
//                tick in the cycle the count sits on its last value. A divider
//                of zero behaves as one (tick every enabled cycle).
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset (count to 0)
//                en   - advance the count
//                clr  - force the count back to 0 (takes priority over en)
//                div  - clk cycles per tick
//                tick - one-cycle pulse on the last count value
//  Revision    : 1.0 - initial release
// ============================================================================
module led_step_prescaler
    import led_scan_pkg::*;
#(
    parameter int DIV_W = c_DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    localparam logic [DIV_W-1:0] c_ONE = DIV_W'(1);

    logic [DIV_W-1:0] r_count;
    logic [DIV_W-1:0] w_last;
    logic             w_wrap;

    assign w_last = (div == '0) ? '0 : (div - c_ONE);
    // >= rather than == so a count left above a shrunken divider still wraps
    assign w_wrap = (r_count >= w_last);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= w_wrap ? '0 : (r_count + c_ONE);
        end
    end

    // Gated by rst so no step is reported while the controller is held in reset
    assign tick = en & w_wrap & ~rst;

endmodule
`default_nettype wire

// File: rtl/led_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : led_scan_ctrl
//  Description : LED scan pattern controller. A prescaler sets the step rate;
//                on each step the FSM advances a SWEEP, BOUNCE or BLINK pattern
//                across N_LEDS outputs. Configuration writes are held pending
//                and applied on a step boundary (or at once when frozen/off).
//  Ports       : clk        - clock, rising edge
//                rst        - synchronous active-high reset
//                run        - 1 advances the pattern, 0 freezes it
//                cfg_valid  - configuration write offered
//                cfg_ready  - configuration write can be accepted
//                cfg_mode   - 0 OFF, 1 SWEEP, 2 BOUNCE, 3 BLINK
//                cfg_div    - clk cycles per pattern step
//                led_out    - registered LED drive
//                step_tick  - one-cycle pulse on each pattern step
//                busy       - FSM is not in IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module led_scan_ctrl
    import led_scan_pkg::*;
#(
    parameter int               N_LEDS       = 8,
    parameter int               DIV_W        = c_DIV_W_DEFAULT,
    parameter logic [DIV_W-1:0] DEFAULT_DIV  = DIV_W'(12_500_000),
    parameter logic [1:0]       DEFAULT_MODE = 2'd2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_mode,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic [N_LEDS-1:0] led_out,
    output logic              step_tick,
    output logic              busy
);

    localparam int                 c_POS_W    = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam logic [c_POS_W-1:0] c_POS_LAST = c_POS_W'(N_LEDS - 1);
    localparam logic [c_POS_W-1:0] c_POS_TURN = c_POS_W'(N_LEDS - 2);
    localparam logic [c_POS_W-1:0] c_POS_ONE  = c_POS_W'(1);
    localparam logic [N_LEDS-1:0]  c_LED_ONE  = N_LEDS'(1);

    // ------------------------------------------------------------------
    // Configuration: active mode/div plus a one-deep pending slot
    // ------------------------------------------------------------------
    mode_t            r_mode;
    mode_t            r_pend_mode;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_pend_div;
    logic             r_pend;
    logic             r_ready;

    logic w_run_en;
    logic w_accept;
    logic w_apply;
    logic w_pend_nxt;

    assign w_run_en = run && (r_mode != c_MODE_OFF);
    assign w_accept = cfg_valid && r_ready;
    // A frozen or OFF controller has no step to wait for, so apply right away
    assign w_apply  = r_pend && (step_tick || !run || (r_mode == c_MODE_OFF));

    assign w_pend_nxt = w_apply ? 1'b0 : (w_accept ? 1'b1 : r_pend);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode      <= DEFAULT_MODE;
            r_div       <= DEFAULT_DIV;
            r_pend_mode <= c_MODE_OFF;
            r_pend_div  <= '0;
            r_pend      <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_pend  <= w_pend_nxt;
            // Registered so ready and led_out both come alive on the same cycle
            r_ready <= ~w_pend_nxt;
            if (w_accept) begin
                r_pend_mode <= cfg_mode;
                r_pend_div  <= cfg_div;
            end
            if (w_apply) begin
                r_mode <= r_pend_mode;
                r_div  <= r_pend_div;
            end
        end
    end

    assign cfg_ready = r_ready;

    // ------------------------------------------------------------------
    // Step prescaler; an apply restarts the step period from zero
    // ------------------------------------------------------------------
    led_step_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (w_run_en),
        .clr  (w_apply),
        .div  (r_div),
        .tick (step_tick)
    );

    // ------------------------------------------------------------------
    // Scan FSM
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_POS_W-1:0]  r_pos;
    logic [c_POS_W-1:0]  w_pos_nxt;
    logic [N_LEDS-1:0]   r_led;
    logic [N_LEDS-1:0]   w_led_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= first_state(DEFAULT_MODE);
            r_pos   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pos   <= w_pos_nxt;
        end
    end

    // Next state: an apply wins over a coincident step and consumes it
    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        if (w_apply) begin
            w_state_nxt = first_state(r_pend_mode);
            w_pos_nxt   = '0;
        end else if (step_tick) begin
            case (r_state)
                c_ST_IDLE: begin
                    w_state_nxt = c_ST_IDLE;
                end
                c_ST_FWD: begin
                    if (r_pos == c_POS_LAST) begin
                        if (r_mode == c_MODE_SWEEP) begin
                            w_state_nxt = c_ST_BLANK;
                            w_pos_nxt   = '0;
                        end else begin
                            // Turn around without repeating the far endpoint
                            w_state_nxt = c_ST_REV;
                            w_pos_nxt   = c_POS_TURN;
                        end
                    end else begin
                        w_pos_nxt = r_pos + c_POS_ONE;
                    end
                end
                c_ST_REV: begin
                    if (r_pos == '0) begin
                        // Near endpoint was just shown; resume forward at 1
                        w_state_nxt = c_ST_FWD;
                        w_pos_nxt   = c_POS_ONE;
                    end else begin
                        w_pos_nxt = r_pos - c_POS_ONE;
                    end
                end
                c_ST_BLANK: begin
                    if (r_pos == c_POS_LAST) begin
                        w_state_nxt = c_ST_FWD;
                        w_pos_nxt   = '0;
                    end else begin
                        w_pos_nxt = r_pos + c_POS_ONE;
                    end
                end
                c_ST_BLK_ON: begin
                    w_state_nxt = c_ST_BLK_OFF;
                end
                c_ST_BLK_OFF: begin
                    w_state_nxt = c_ST_BLK_ON;
                end
                default: begin
                    w_state_nxt = first_state(r_mode);
                    w_pos_nxt   = '0;
                end
            endcase
        end
    end

    // Output decode from the next state, so the LED register shows the new
    // pattern in the cycle right after the step
    always_comb begin
        w_led_nxt = '0;
        case (w_state_nxt)
            c_ST_FWD, c_ST_REV: w_led_nxt = c_LED_ONE << w_pos_nxt;
            c_ST_BLK_ON:        w_led_nxt = '1;
            default:            w_led_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_led <= '0;
        end else begin
            r_led <= w_led_nxt;
        end
    end

    assign led_out = r_led;
    assign busy    = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_led_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_scan_ctrl
//  Description : Self-checking bench for led_scan_ctrl. Stimulus pushes the
//                LED value expected after each step_tick (and the expected
//                spacing between ticks) into a queue; a monitor pops and
//                compares whenever a step_tick is observed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_scan_ctrl;

    localparam int c_N  = 8;
    localparam int c_DW = 24;

    logic            clk = 1'b0;
    logic            rst;
    logic            run;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [1:0]      cfg_mode;
    logic [c_DW-1:0] cfg_div;
    logic [c_N-1:0]  led_out;
    logic            step_tick;
    logic            busy;

    always #5 clk = ~clk;

    led_scan_ctrl #(
        .N_LEDS       (c_N),
        .DIV_W        (c_DW),
        .DEFAULT_DIV  (24'd4),
        .DEFAULT_MODE (2'd2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_mode  (cfg_mode),
        .cfg_div   (cfg_div),
        .led_out   (led_out),
        .step_tick (step_tick),
        .busy      (busy)
    );

    typedef struct {
        logic [7:0] led;
        int         gap;   // expected cycles since previous tick, 0 = don't care
    } exp_t;

    exp_t q[$];
    int   total      = 0;
    int   bad        = 0;
    int   cyc        = 0;
    int   last_tick  = 0;
    int   tick_count = 0;
    bit   chk_pend   = 1'b0;
    exp_t cur;
    int   seen_gap   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] l, input int g);
        exp_t e;
        e.led = l;
        e.gap = g;
        q.push_back(e);
    endtask

    // Inputs change just after the rising edge, outputs are read on the falling edge
    task automatic at_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while ((q.size() != 0 || chk_pend) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || chk_pend) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d expectations left, wanted 0", q.size());
            q.delete();
            chk_pend = 1'b0;
        end
    endtask

    // Monitor: on each tick pop an expectation, compare led_out one cycle later
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (chk_pend) begin
                check("led_after_tick", 32'(led_out), 32'(cur.led));
                if (cur.gap != 0) check("tick_gap", 32'(seen_gap), 32'(cur.gap));
                chk_pend = 1'b0;
            end
            if (step_tick === 1'b1) begin
                tick_count++;
                if (q.size() > 0) begin
                    cur      = q.pop_front();
                    seen_gap = cyc - last_tick;
                    chk_pend = 1'b1;
                end
                last_tick = cyc;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, wanted finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  n;
        int  snap;
        bit  found;
        logic [7:0] bounce [15];

        rst       = 1'b1;
        run       = 1'b1;
        cfg_valid = 1'b0;
        cfg_mode  = 2'd0;
        cfg_div   = '0;

        // ---------------- reset, then default BOUNCE div=4 ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_led", 32'(led_out), 32'h0);
        check("rst_tick", 32'(step_tick), 32'h0);
        check("rst_ready", 32'(cfg_ready), 32'h0);
        check("rst_busy", 32'(busy), 32'h1);

        bounce = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                   8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        for (int i = 0; i < 15; i++) push(bounce[i], (i == 0) ? 0 : 4);
        at_cycle();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_ready", 32'(cfg_ready), 32'h1);
        check("post_rst_led", 32'(led_out), 32'h01);
        wait_drain(200);

        // ---------------- freeze at led 10 ----------------
        found = 1'b0;
        n = 0;
        while (!found && n < 100) begin
            @(negedge clk);
            n++;
            if (step_tick === 1'b1 && led_out == 8'h08) found = 1'b1;
        end
        check("reach_08_tick", 32'(found), 32'h1);
        at_cycle();
        run  = 1'b0;
        snap = tick_count;
        repeat (20) @(negedge clk);
        check("freeze_led", 32'(led_out), 32'h10);
        check("freeze_no_tick", 32'(tick_count), 32'(snap));

        push(8'h20, 0);
        at_cycle();
        run = 1'b1;
        n = 0;
        @(negedge clk);
        while (step_tick !== 1'b1 && n < 10) begin
            n++;
            @(negedge clk);
        end
        check("resume_latency", 32'(n), 32'd3);
        check("ready_before_write", 32'(cfg_ready), 32'h1);

        // ---------------- SWEEP write at pos 5, second write stalls ----------------
        push(8'h01, 4);
        push(8'h02, 1);
        push(8'h01, 1);
        for (int i = 1; i < 8; i++) push(8'(1 << i), 1);
        for (int i = 0; i < 8; i++) push(8'h00, 1);
        push(8'h01, 1);
        at_cycle();
        cfg_valid = 1'b1;
        cfg_mode  = 2'd1;
        cfg_div   = 24'd1;
        @(negedge clk);
        check("write_at_pos5", 32'(led_out), 32'h20);
        @(negedge clk);
        check("pending_ready_c1", 32'(cfg_ready), 32'h0);
        @(negedge clk);
        check("pending_ready_c2", 32'(cfg_ready), 32'h0);
        @(negedge clk);
        check("pending_ready_c3", 32'(cfg_ready), 32'h0);
        @(negedge clk);
        check("ready_after_apply", 32'(cfg_ready), 32'h1);
        at_cycle();
        cfg_valid = 1'b0;
        @(negedge clk);
        check("second_write_taken", 32'(cfg_ready), 32'h0);
        @(negedge clk);
        check("second_apply_ready", 32'(cfg_ready), 32'h1);
        wait_drain(100);

        // ---------------- BLINK div=0, applied while frozen ----------------
        at_cycle();
        run       = 1'b0;
        cfg_valid = 1'b1;
        cfg_mode  = 2'd3;
        cfg_div   = 24'd0;
        @(negedge clk);
        check("blink_ready", 32'(cfg_ready), 32'h1);
        at_cycle();
        cfg_valid = 1'b0;
        @(negedge clk);
        check("blink_pending", 32'(cfg_ready), 32'h0);
        @(negedge clk);
        check("blink_apply_frozen", 32'(led_out), 32'hFF);
        for (int i = 0; i < 6; i++) push((i % 2 == 0) ? 8'h00 : 8'hFF, (i == 0) ? 0 : 1);
        at_cycle();
        run = 1'b1;
        wait_drain(50);

        // ---------------- OFF ----------------
        at_cycle();
        cfg_valid = 1'b1;
        cfg_mode  = 2'd0;
        cfg_div   = 24'd0;
        at_cycle();
        cfg_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("off_led", 32'(led_out), 32'h0);
        check("off_busy", 32'(busy), 32'h0);
        check("off_ready", 32'(cfg_ready), 32'h1);
        snap = tick_count;
        repeat (5) @(negedge clk);
        check("off_no_tick", 32'(tick_count), 32'(snap));

        // ---------------- reset while a write is pending ----------------
        at_cycle();
        cfg_valid = 1'b1;
        cfg_mode  = 2'd3;
        cfg_div   = 24'd10;
        at_cycle();
        cfg_valid = 1'b0;
        @(negedge clk);
        check("off_apply_pending", 32'(cfg_ready), 32'h0);
        at_cycle();
        cfg_valid = 1'b1;
        cfg_mode  = 2'd1;
        cfg_div   = 24'd1;
        @(negedge clk);
        check("blink10_led", 32'(led_out), 32'hFF);
        check("blink10_busy", 32'(busy), 32'h1);
        at_cycle();
        cfg_valid = 1'b0;
        @(negedge clk);
        check("sweep_pending", 32'(cfg_ready), 32'h0);
        at_cycle();
        rst = 1'b1;
        at_cycle();
        @(negedge clk);
        check("rst2_led", 32'(led_out), 32'h0);
        check("rst2_ready", 32'(cfg_ready), 32'h0);
        check("rst2_tick", 32'(step_tick), 32'h0);
        check("rst2_busy", 32'(busy), 32'h1);
        snap = tick_count;
        push(8'h02, 0);
        push(8'h04, 4);
        push(8'h08, 4);
        at_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rst2_no_tick", 32'(tick_count), 32'(snap));
        @(negedge clk);
        check("rst2_post_ready", 32'(cfg_ready), 32'h1);
        check("rst2_post_led", 32'(led_out), 32'h01);
        wait_drain(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_scan_ctrl.md
LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 SHALL have parameter N_LEDS, default 8: width of led_out and number of scan positions.
REQ-002 SHALL have parameter DIV_W, default 24: width of the step divider.
REQ-003 SHALL have parameter DEFAULT_DIV, default 12_500_000: step divider after reset.
REQ-004 SHALL have parameter DEFAULT_MODE, default 2'd2 (BOUNCE): mode after reset.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port run, input, 1 bit: 1 = advance the pattern; 0 = freeze.
REQ-008 SHALL have port cfg_valid, input, 1 bit: a configuration write is offered.
REQ-009 SHALL have port cfg_ready, output, 1 bit: a configuration write can be accepted.
REQ-010 SHALL have port cfg_mode, input, 2 bits: 0 OFF, 1 SWEEP, 2 BOUNCE, 3 BLINK.
REQ-011 SHALL have port cfg_div, input, DIV_W bits: clk cycles per step.
REQ-012 SHALL have port led_out, output, N_LEDS bits: registered LED drive.
REQ-013 SHALL have port step_tick, output, 1 bit: one-cycle pulse on each pattern step.
REQ-014 SHALL have port busy, output, 1 bit: 1 when the FSM is not in IDLE.

Function
REQ-015 SHALL implement a prescaler count 0..div-1 that advances only while run=1 and mode!=OFF; step_tick SHALL pulse in the cycle where count==div-1, and count SHALL return to 0.
REQ-016 SHALL treat div=0 as div=1, so step_tick is high every running cycle.
REQ-017 SHALL implement FSM states IDLE, FWD, REV, BLANK, BLK_ON, BLK_OFF, with position pos in 0..N_LEDS-1.
REQ-018 SHALL hold the FSM in IDLE with led_out=0 in mode OFF.
REQ-019 SHALL, in SWEEP, show FWD pos 0→N_LEDS-1 with led_out=1<<pos, then BLANK for N_LEDS steps with led_out=0, then FWD at pos 0; the period is 2*N_LEDS steps.
REQ-020 SHALL, in BOUNCE, show FWD 0→N_LEDS-1 then REV N_LEDS-2→0, with no repeated endpoint; the period is 2*N_LEDS-2 steps.
REQ-021 SHALL, in BLINK, alternate BLK_ON (led_out all ones) and BLK_OFF (all zeros) on every step.
REQ-022 SHALL change state and pos only on step_tick; led_out SHALL reflect the new state one cycle after the step_tick cycle.
REQ-023 SHALL hold the prescaler, state, pos and led_out while run=0.
REQ-024 SHALL accept a configuration when cfg_valid && cfg_ready, latching mode and div into a pending register; cfg_ready SHALL be !pending.
REQ-025 SHALL apply the pending configuration at the next step_tick, or on the next cycle if run=0 or the active mode is OFF.
REQ-026 SHALL, on applying a configuration, clear the prescaler, set pos=0, enter the first state of the new mode (FWD / BLK_ON / IDLE), and clear pending.
REQ-027 SHALL give apply priority when apply and a step_tick coincide: the step is consumed by the apply, and the new mode's first pattern appears one cycle later.
REQ-028 SHALL not accept a write while cfg_valid is held during pending; the write is accepted on the cycle after the apply.

Reset
REQ-029 SHALL, with rst=1, set: mode=DEFAULT_MODE, div=DEFAULT_DIV, pending=0, prescaler=0, pos=0, state=FWD (or IDLE if DEFAULT_MODE=OFF), led_out=0, step_tick=0, cfg_ready=0.
REQ-030 SHALL drive cfg_ready=1 and led_out equal to the state pattern from the first cycle after rst deasserts.
REQ-031 SHALL make rst mid-operation discard any pending configuration.

Structure
REQ-032 SHALL place the mode encoding, the FSM state encoding and the DIV_W default in a shared package led_scan_pkg.
REQ-033 SHALL implement the prescaler as sub-module led_step_prescaler (ports: clk, rst, en, clr, div, tick).

Verification
REQ-034 SHALL test reset then BOUNCE with div=4, run=1 -> step_tick every 4 cycles; led_out 01,02,04,…,80,40,…,02,01,02; period 14 steps.
REQ-035 SHALL test SWEEP with div=1 -> led_out 01..80 over 8 cycles, then 8 cycles of 00, then 01.
REQ-036 SHALL test BLINK with div=0 -> led_out alternates FF/00 every cycle and step_tick stays high.
REQ-037 SHALL test run=0 at led_out=10 for 20 cycles -> led_out stays 10 with no step_tick; after run=1 it resumes with 20 after div cycles.
REQ-038 SHALL test a write of SWEEP mid-BOUNCE at pos 5 -> cfg_ready falls; at the next step_tick the pattern restarts at 01; cfg_ready then rises; a second write during pending stalls.
REQ-039 SHALL test rst asserted while pending -> outputs match REQ-029 and DEFAULT_MODE resumes, ignoring the pending configuration.
